// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer SPI configuration path.
package synth_pkg;

  localparam int unsigned SPI_ADDR_W = 4;
  localparam int unsigned SPI_DATA_W = 16;

  // Register map consumed by synth_top
  localparam int unsigned REG_FREQ = 0;
  localparam int unsigned REG_VOL  = 1;
  localparam int unsigned REG_WAVE = 2;
  localparam int unsigned REG_ENV  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizers for asynchronous SPI pad inputs.

// Plain SYNC_STAGES-deep synchronizer; INIT is the reset (idle) level.
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw input through the chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  // Chain register, reset to the idle level
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {SYNC_STAGES{INIT}};
    else     sync_q <= sync_d;
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// Synchronizer plus one history flop giving a single-cycle rising-edge pulse.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout)
  );

  // Remember last synced level for edge detection
  always_comb begin
    prev_d = dout;
  end

  // History flop
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise = dout & ~prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// Write-only SPI mode-0 slave holding the synthesizer register bank.
module spi_reg_slave
  import synth_pkg::*;
#(
  parameter int unsigned ADDR_W      = SPI_ADDR_W,
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       spi_clk,
  input  logic                       spi_mosi,
  input  logic                       spi_nss,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       addr_err
);

  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [ADDR_W:0]   REG_LIM  = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_s, sclk_rise, mosi_s, nss_s;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_clk),
    .dout (sclk_s),
    .rise (sclk_rise)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_mosi),
    .dout (mosi_s)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_nss (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_nss),
    .dout (nss_s)
  );

  spi_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [FRAME_W-1:0]         shift_q, shift_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic                       wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic                       addr_err_q, addr_err_d;

  logic [FRAME_W-1:0] frame;
  logic [ADDR_W-1:0]  f_addr;
  logic [DATA_W-1:0]  f_data;

  // Full frame as seen on the final bit: shifted history plus the current bit
  always_comb begin
    frame  = {shift_q[FRAME_W-2:0], mosi_s};
    f_addr = frame[FRAME_W-1 -: ADDR_W];
    f_data = frame[DATA_W-1:0];
  end

  // Frame FSM, shifter and commit logic; nss high always wins over a clock edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    regs_d     = regs_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    addr_err_d = addr_err_q;
    unique case (state_q)
      IDLE: begin
        if (!nss_s) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (nss_s) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          shift_d = frame;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = DONE;
            if ({1'b0, f_addr} < REG_LIM) begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (f_addr == i[ADDR_W-1:0]) regs_d[i*DATA_W +: DATA_W] = f_data;
              end
              wr_addr_d = f_addr;
              wr_stb_d  = 1'b1;
            end else begin
              addr_err_d = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (nss_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register bank
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      regs_q     <= '0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      regs_q     <= regs_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign regs     = regs_q;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign addr_err = addr_err_q;

  // Synced spi_clk level is only consumed through its edge pulse
  logic unused_sclk;
  assign unused_sclk = sclk_s;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: SPI at clk/8, hand-computed register images.
module tb_spi_reg_slave;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned RW     = NREGS * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              spi_clk, spi_mosi, spi_nss;
  logic [RW-1:0]     regs;
  logic              wr_stb;
  logic [ADDR_W-1:0] wr_addr;
  logic              addr_err;

  int n_vec = 0;
  int n_err = 0;
  int stb_cnt = 0;
  int stb_base;
  logic [RW-1:0] exp_regs;

  spi_reg_slave #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .NUM_REGS    (NREGS),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_nss  (spi_nss),
    .regs     (regs),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_stb) stb_cnt <= stb_cnt + 1;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Shift n bits of val, MSB first; data changes while spi_clk is low
  task automatic spi_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = val[i];
      #40 spi_clk = 1'b1;
      #40 spi_clk = 1'b0;
    end
  endtask

  task automatic spi_start();
    spi_nss = 1'b0;
    #80;
  endtask

  task automatic spi_end();
    #40 spi_nss = 1'b1;
    #160;
  endtask

  initial begin
    rst = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_nss = 1'b1;
    exp_regs = '0;
    repeat (2) @(negedge clk);
    check("rst_regs", regs, '0);
    check("rst_stb", RW'(wr_stb), '0);
    check("rst_err", RW'(addr_err), '0);
    check("rst_waddr", RW'(wr_addr), '0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clock edges with nss high must be ignored
    spi_bits(32'hFFFFF, 20);
    #200;
    check("nss_hi_regs", regs, '0);
    check("nss_hi_stb", RW'(stb_cnt), '0);

    // Valid write; regs checked 4 clk after last rising edge
    stb_base = stb_cnt;
    spi_start();
    spi_bits({12'h0, 4'h2, 16'hBEEF}, 20);
    exp_regs[2*DATA_W +: DATA_W] = 16'hBEEF;
    check("wr2_latency", RW'(regs[2*DATA_W +: DATA_W]), RW'(16'hBEEF));
    spi_end();
    check("wr2_regs", regs, exp_regs);
    check("wr2_stbs", RW'(stb_cnt - stb_base), RW'(1));
    check("wr2_waddr", RW'(wr_addr), RW'(2));

    // Aborted after 12 bits
    stb_base = stb_cnt;
    spi_start();
    spi_bits({12'h0, 4'h1, 16'h1234} >> 8, 12);
    spi_end();
    check("abort_regs", regs, exp_regs);
    check("abort_stbs", RW'(stb_cnt - stb_base), '0);
    spi_start();
    spi_bits({12'h0, 4'h1, 16'h00FF}, 20);
    spi_end();
    exp_regs[1*DATA_W +: DATA_W] = 16'h00FF;
    check("wr1_regs", regs, exp_regs);
    check("wr1_stbs", RW'(stb_cnt - stb_base), RW'(1));
    check("wr1_waddr", RW'(wr_addr), RW'(1));

    // Out-of-range address
    stb_base = stb_cnt;
    spi_start();
    spi_bits({12'h0, 4'hA, 16'h5555}, 20);
    spi_end();
    check("oor_regs", regs, exp_regs);
    check("oor_stbs", RW'(stb_cnt - stb_base), '0);
    check("oor_err", RW'(addr_err), RW'(1));
    check("oor_waddr", RW'(wr_addr), RW'(1));
    spi_start();
    spi_bits({12'h0, 4'h4, 16'h1111}, 20);
    spi_end();
    exp_regs[4*DATA_W +: DATA_W] = 16'h1111;
    check("sticky_regs", regs, exp_regs);
    check("sticky_err", RW'(addr_err), RW'(1));

    // Overlong frame: only the first 20 bits count
    stb_base = stb_cnt;
    spi_start();
    spi_bits({8'h0, 4'h3, 16'hA5A5, 4'hF}, 24);
    spi_end();
    exp_regs[3*DATA_W +: DATA_W] = 16'hA5A5;
    check("long_regs", regs, exp_regs);
    check("long_stbs", RW'(stb_cnt - stb_base), RW'(1));
    check("long_waddr", RW'(wr_addr), RW'(3));

    // Reset mid-frame
    spi_start();
    spi_bits({12'h0, 4'h5, 16'h6789} >> 10, 10);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_regs = '0;
    check("mid_rst_regs", regs, '0);
    check("mid_rst_err", RW'(addr_err), '0);
    spi_end();
    stb_base = stb_cnt;
    spi_start();
    spi_bits({12'h0, 4'h0, 16'h0042}, 20);
    spi_end();
    exp_regs[0 +: DATA_W] = 16'h0042;
    check("post_rst_regs", regs, exp_regs);
    check("post_rst_stbs", RW'(stb_cnt - stb_base), RW'(1));
    check("post_rst_waddr", RW'(wr_addr), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
